// File: rtl/num_conv_pipe.sv
// num_conv_pipe
//   Two-stage pipelined number-format converter. Each accepted operand carries
//   its own conversion mode; results leave in acceptance order with an error
//   flag for values that have no representation in the target format. A
//   saturating counter tallies error results taken by the downstream consumer.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous reset, active low
//   in_valid   operand valid
//   in_ready   converter can take an operand this cycle (combinational)
//   in_mode    00 U2->SM, 01 SM->U2, 10 U2->U1, 11 U1->U2
//   in_data    operand, M bits
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   converted result, M bits
//   out_error  result not representable (out_data forced to zero)
//   cnt_clr    synchronous clear of err_cnt (wins over a same-cycle increment)
//   err_cnt    saturating count of error results accepted downstream
module num_conv_pipe #(
  parameter int M         = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [M-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M-1:0]         out_data,
  output logic                 out_error,
  input  logic                 cnt_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [M-1:0]         MOST_NEG = {1'b1, {(M-1){1'b0}}};
  localparam logic [M-1:0]         ONE      = {{(M-1){1'b0}}, 1'b1};
  localparam logic [M-2:0]         ONE_LOW  = {{(M-2){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;

  // Stage 1: raw operand and mode
  logic         v1_reg;
  logic [1:0]   mode1_reg;
  logic [M-1:0] data1_reg;

  // Stage 2: converted result
  logic         v2_reg;
  logic [M-1:0] res2_reg;
  logic         err2_reg;

  logic [ERR_CNT_W-1:0] err_cnt_reg;

  logic adv1, adv2;

  // A stage may advance when it is empty or its successor frees up this cycle.
  assign adv2     = !v2_reg || out_ready;
  assign adv1     = !v1_reg || adv2;
  assign in_ready = adv1;

  // Conversion of the stage-1 operand
  logic         sign;
  logic [M-2:0] neg_low;
  logic [M-1:0] mag;
  logic [M-1:0] res_next;
  logic         err_next;

  always_comb begin
    sign     = data1_reg[M-1];
    // Low M-1 bits of the two's-complement negation; the top bit of -x is
    // never needed because it is replaced by the sign in SM form.
    neg_low  = ~data1_reg[M-2:0] + ONE_LOW;
    mag      = {1'b0, data1_reg[M-2:0]};
    res_next = data1_reg;
    err_next = 1'b0;
    case (mode1_reg)
      2'b00: begin
        if (data1_reg == MOST_NEG) begin
          res_next = '0;
          err_next = 1'b1;
        end else if (sign) begin
          res_next = {1'b1, neg_low};
        end
      end
      2'b01: begin
        // Negative zero yields -0 = 0 naturally.
        if (sign) res_next = -mag;
      end
      2'b10: begin
        if (data1_reg == MOST_NEG) begin
          res_next = '0;
          err_next = 1'b1;
        end else if (sign) begin
          res_next = data1_reg - ONE;
        end
      end
      default: begin
        // All-ones (negative zero) wraps to 0.
        if (sign) res_next = data1_reg + ONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      mode1_reg <= 2'b00;
      data1_reg <= '0;
    end else if (adv1) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        mode1_reg <= in_mode;
        data1_reg <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg   <= 1'b0;
      res2_reg <= '0;
      err2_reg <= 1'b0;
    end else if (adv2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        res2_reg <= res_next;
        err2_reg <= err_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (cnt_clr) begin
      err_cnt_reg <= '0;
    end else if (v2_reg && out_ready && err2_reg && err_cnt_reg != CNT_MAX) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign out_valid = v2_reg;
  assign out_data  = res2_reg;
  assign out_error = v2_reg && err2_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_num_conv_pipe.sv
// Bench for num_conv_pipe: an 8-bit instance (2-bit error counter) for the
// directed and random streams, and a 4-bit instance swept exhaustively.
module tb_num_conv_pipe;

  logic clk;
  logic rst_n;

  // Instance A: M=8, ERR_CNT_W=2
  logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_error_a, cnt_clr_a;
  logic [1:0] in_mode_a;
  logic [7:0] in_data_a, out_data_a;
  logic [1:0] err_cnt_a;

  // Instance B: M=4, ERR_CNT_W=8
  logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_error_b, cnt_clr_b;
  logic [1:0] in_mode_b;
  logic [3:0] in_data_b, out_data_b;
  logic [7:0] err_cnt_b;

  num_conv_pipe #(.M(8), .ERR_CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_mode(in_mode_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_error(out_error_a), .cnt_clr(cnt_clr_a), .err_cnt(err_cnt_a)
  );

  num_conv_pipe #(.M(4), .ERR_CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_mode(in_mode_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_error(out_error_b), .cnt_clr(cnt_clr_b), .err_cnt(err_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int din;
    int d;
    int e;
    int ts;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit lat_chk   = 0;
  bit rnd_ready = 0;
  int pend_a_d, pend_a_e, pend_b_d, pend_b_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decode the operand to an integer value in its source format,
  // then encode that value in the target format.
  function automatic void ref_conv(input int w, input int mode, input int x,
                                   output int r, output int e);
    int half, full, v;
    half = 1 << (w - 1);
    full = 1 << w;
    r = 0;
    e = 0;
    case (mode)
      0: begin // U2 -> SM
        v = (x >= half) ? x - full : x;
        if (v == -half) e = 1;
        else if (v < 0) r = half + (-v);
        else r = v;
      end
      1: begin // SM -> U2
        v = (x >= half) ? -(x % half) : (x % half);
        r = (v + full) % full;
      end
      2: begin // U2 -> U1
        v = (x >= half) ? x - full : x;
        if (v == -half) e = 1;
        else if (v < 0) r = (full - 1) + v;
        else r = v;
      end
      default: begin // U1 -> U2
        v = (x >= half) ? -((full - 1) - x) : x;
        r = (v + full) % full;
      end
    endcase
  endfunction

  // One clock: score handshakes at the falling edge, then advance past the
  // next rising edge.
  task automatic step();
    exp_t t;
    @(negedge clk);
    if (out_valid_a && out_ready_a) begin
      chk("a_expected_pending", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        t = qa.pop_front();
        $display("A mode=%0d in=%02h out=%02h err=%0d (ref %02h/%0d)",
                 t.mode, t.din, out_data_a, out_error_a, t.d, t.e);
        chk("a_data", 32'(out_data_a), 32'(t.d));
        chk("a_error", 32'(out_error_a), 32'(t.e));
        if (lat_chk) chk("a_latency", 32'(cyc - t.ts), 2);
      end
    end
    if (in_valid_a && in_ready_a)
      qa.push_back('{mode: int'(in_mode_a), din: int'(in_data_a), d: pend_a_d, e: pend_a_e, ts: cyc});
    if (out_valid_b && out_ready_b) begin
      chk("b_expected_pending", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        t = qb.pop_front();
        $display("B mode=%0d in=%01h out=%01h err=%0d (ref %01h/%0d)",
                 t.mode, t.din, out_data_b, out_error_b, t.d, t.e);
        chk("b_data", 32'(out_data_b), 32'(t.d));
        chk("b_error", 32'(out_error_b), 32'(t.e));
      end
    end
    if (in_valid_b && in_ready_b)
      qb.push_back('{mode: int'(in_mode_b), din: int'(in_data_b), d: pend_b_d, e: pend_b_e, ts: cyc});
    @(posedge clk);
    #1;
    cyc++;
    if (rnd_ready) begin
      out_ready_a = 1'($urandom);
      out_ready_b = 1'($urandom);
    end
  endtask

  task automatic send_a(input int mode, input int x, input int ed, input int ee);
    bit acc;
    acc = 0;
    in_valid_a = 1'b1;
    in_mode_a  = 2'(mode);
    in_data_a  = 8'(x);
    pend_a_d   = ed;
    pend_a_e   = ee;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = in_ready_a;
      step();
    end
    in_valid_a = 1'b0;
    chk("a_accept_in_time", 32'(acc), 1);
  endtask

  task automatic send_b(input int mode, input int x);
    bit acc;
    int r, e;
    ref_conv(4, mode, x, r, e);
    acc = 0;
    in_valid_b = 1'b1;
    in_mode_b  = 2'(mode);
    in_data_b  = 4'(x);
    pend_b_d   = r;
    pend_b_e   = e;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = in_ready_b;
      step();
    end
    in_valid_b = 1'b0;
    chk("b_accept_in_time", 32'(acc), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_in_time", 32'(qa.size() + qb.size()), 0);
  endtask

  initial begin
    int r, e, m, x;
    rst_n = 1'b0;
    in_valid_a = 0; in_mode_a = 0; in_data_a = 0; out_ready_a = 1; cnt_clr_a = 0;
    in_valid_b = 0; in_mode_b = 0; in_data_b = 0; out_ready_b = 1; cnt_clr_b = 0;
    pend_a_d = 0; pend_a_e = 0; pend_b_d = 0; pend_b_e = 0;
    #12;
    chk("reset_out_valid", 32'(out_valid_a), 0);
    chk("reset_out_data", 32'(out_data_a), 0);
    chk("reset_out_error", 32'(out_error_a), 0);
    chk("reset_err_cnt", 32'(err_cnt_a), 0);
    chk("reset_in_ready", 32'(in_ready_a), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: back-to-back conversions, no backpressure, fixed latency
    lat_chk = 1;
    send_a(0, 8'hFB, 8'h85, 0);
    send_a(1, 8'h85, 8'hFB, 0);
    send_a(2, 8'hFB, 8'hFA, 0);
    send_a(3, 8'hFA, 8'hFB, 0);
    drain();

    // 2: boundary operands
    send_a(0, 8'h80, 8'h00, 1);
    send_a(2, 8'h80, 8'h00, 1);
    send_a(1, 8'h80, 8'h00, 0);
    send_a(3, 8'hFF, 8'h00, 0);
    send_a(0, 8'h7F, 8'h7F, 0);
    drain();
    lat_chk = 0;
    chk("err_cnt_after_boundaries", 32'(err_cnt_a), 2);

    // 3: backpressure with 5 operands
    out_ready_a = 1'b0;
    chk("bp_ready_empty", 32'(in_ready_a), 1);
    send_a(0, 8'hFB, 8'h85, 0);
    chk("bp_ready_one", 32'(in_ready_a), 1);
    send_a(2, 8'h81, 8'h80, 0);
    in_valid_a = 1'b1; in_mode_a = 2'd1; in_data_a = 8'h83; pend_a_d = 8'hFD; pend_a_e = 0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready_low", 32'(in_ready_a), 0);
      chk("bp_out_valid", 32'(out_valid_a), 1);
      chk("bp_out_data_stable", 32'(out_data_a), 8'h85);
      step();
    end
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    send_a(1, 8'h83, 8'hFD, 0);
    send_a(3, 8'h80, 8'h81, 0);
    send_a(0, 8'h05, 8'h05, 0);
    drain();

    // 4: saturating error counter and clear priority
    cnt_clr_a = 1'b1;
    step();
    cnt_clr_a = 1'b0;
    chk("cnt_cleared", 32'(err_cnt_a), 0);
    for (int i = 0; i < 5; i++) send_a(0, 8'h80, 8'h00, 1);
    drain();
    chk("cnt_saturated", 32'(err_cnt_a), 3);
    send_a(2, 8'h80, 8'h00, 1);
    step();
    chk("clr_hs_valid", 32'(out_valid_a && out_error_a), 1);
    chk("cnt_before_clr", 32'(err_cnt_a), 3);
    cnt_clr_a = 1'b1;
    step();
    cnt_clr_a = 1'b0;
    chk("cnt_clr_wins", 32'(err_cnt_a), 0);

    // 5: asynchronous reset with both stages full
    send_a(0, 8'h80, 8'h00, 1);
    drain();
    chk("cnt_one_error", 32'(err_cnt_a), 1);
    out_ready_a = 1'b0;
    send_a(1, 8'h81, 8'hFF, 0);
    send_a(1, 8'h82, 8'hFE, 0);
    chk("full_in_ready_low", 32'(in_ready_a), 0);
    chk("full_out_valid", 32'(out_valid_a), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid_a), 0);
    chk("async_rst_err_cnt", 32'(err_cnt_a), 0);
    chk("async_rst_out_data", 32'(out_data_a), 0);
    qa.delete();
    #2;
    rst_n = 1'b1;
    out_ready_a = 1'b1;
    lat_chk = 1;
    send_a(0, 8'h01, 8'h01, 0);
    drain();
    lat_chk = 0;

    // 6: exhaustive 4-bit sweep and random streams under random out_ready
    rnd_ready = 1;
    for (int md = 0; md < 4; md++)
      for (int v = 0; v < 16; v++)
        send_b(md, v);
    for (int i = 0; i < 60; i++) begin
      m = int'($urandom_range(0, 3));
      x = int'($urandom_range(0, 255));
      ref_conv(8, m, x, r, e);
      send_a(m, x, r, e);
      if ($urandom_range(0, 3) == 0) step();
    end
    for (int i = 0; i < 60; i++) begin
      send_b(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) step();
    end
    rnd_ready = 0;
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;
    drain();
    chk("b_idle_after_drain", 32'(out_valid_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
